q15_to_ieee754: RTL

Q15_TO_IEEE754 -- requirements
Module: q15_to_ieee754

---
 rtl/q15_to_ieee754.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/q15_to_ieee754.sv
// q15_to_ieee754
//   Converts one pair of signed 16-bit fixed-point samples (sine and cosine)
//   to IEEE754 single precision. Each lane finds its leading one by shifting
//   left one bit per clock, and then the sign, exponent and mantissa fields
//   are packed. The conversion is exact because 15 fraction bits fit in the
//   23-bit mantissa.
//
// Parameters
//   FRAC_BITS    binary-point position of the inputs (value = x / 2^FRAC_BITS)
//
// Ports
//   clk          rising-edge clock
//   rst          asynchronous reset, active low
//   valid_in     conversion request; accepted only while idle
//   sin_q15      signed sine sample
//   cos_q15      signed cosine sample
//   sin_ieee754  float encoding of sin_q15, held until the next result
//   cos_ieee754  float encoding of cos_q15, held until the next result
//   busy         high while a conversion is in flight
//   done         one-cycle pulse: both results are valid
//
// Build option
//   Q2F_EARLY_DONE_EN  when defined, normalization ends as soon as both lanes
//                      are normalized. Latency is then 2 + max shift count.
//                      When undefined, normalization always takes 15 cycles.
//                      The result values are the same in both builds.

module q15_to_ieee754 #(
  parameter int FRAC_BITS = 15
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               valid_in,
  input  logic signed [15:0] sin_q15,
  input  logic signed [15:0] cos_q15,
  output logic        [31:0] sin_ieee754,
  output logic        [31:0] cos_ieee754,
  output logic               busy,
  output logic               done
);

  typedef enum logic [1:0] {IDLE, NORM, PACK} state_t;

  // A magnitude that is already normalized at bit 15 has value
  // mag / 2^FRAC_BITS = 1.x * 2^(15 - FRAC_BITS). Each left shift lowers
  // the exponent by one.
  localparam logic [7:0] EXP_BASE = 8'(127 + 15 - FRAC_BITS);

  state_t      state, state_nx;
  logic        sin_sign, cos_sign;
  logic [15:0] sin_mag, cos_mag;
  logic [3:0]  sin_sc, cos_sc;
  logic        sin_norm, cos_norm;
  logic [15:0] sin_abs, cos_abs;
`ifndef Q2F_EARLY_DONE_EN
  logic [3:0]  cyc_cnt;
`endif

  // The unsigned result is correct for -32768 as well: its magnitude is 0x8000.
  assign sin_abs = sin_q15[15] ? (~sin_q15 + 16'd1) : sin_q15;
  assign cos_abs = cos_q15[15] ? (~cos_q15 + 16'd1) : cos_q15;

  // A lane stops shifting once its leading one reaches bit 15. A zero
  // magnitude has no leading one, so it counts as normalized at once.
  assign sin_norm = sin_mag[15] || (sin_mag == 16'd0);
  assign cos_norm = cos_mag[15] || (cos_mag == 16'd0);

  function automatic logic [31:0] pack(input logic sign, input logic [15:0] mag,
                                       input logic [3:0] sc);
    if (mag == 16'd0) return 32'h0000_0000;  // positive zero, whatever the sign
    // The leading one at mag[15] is implicit and is not stored.
    return {sign, EXP_BASE - {4'd0, sc}, mag[14:0], 8'd0};
  endfunction

  // NOTE: give every combinational output a default before the case. If any
  // path leaves it unassigned, synthesis infers a latch.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (valid_in) state_nx = NORM;
      NORM: begin
`ifdef Q2F_EARLY_DONE_EN
        if (sin_norm && cos_norm) state_nx = PACK;
`else
        if (cyc_cnt == 4'd14) state_nx = PACK;
`endif
      end
      PACK:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only. Every register
  // then samples the values from before the edge, so the order of the
  // statements does not matter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      busy        <= 1'b0;
      done        <= 1'b0;
      sin_ieee754 <= 32'd0;
      cos_ieee754 <= 32'd0;
      sin_sign    <= 1'b0;
      cos_sign    <= 1'b0;
      sin_mag     <= 16'd0;
      cos_mag     <= 16'd0;
      sin_sc      <= 4'd0;
      cos_sc      <= 4'd0;
`ifndef Q2F_EARLY_DONE_EN
      cyc_cnt     <= 4'd0;
`endif
    end else begin
      state <= state_nx;
      busy  <= (state_nx != IDLE);
      done  <= (state == PACK);
      case (state)
        IDLE: begin
          if (valid_in) begin
            sin_sign <= sin_q15[15];
            cos_sign <= cos_q15[15];
            sin_mag  <= sin_abs;
            cos_mag  <= cos_abs;
            sin_sc   <= 4'd0;
            cos_sc   <= 4'd0;
`ifndef Q2F_EARLY_DONE_EN
            cyc_cnt  <= 4'd0;
`endif
          end
        end
        NORM: begin
          if (!sin_norm) begin
            sin_mag <= {sin_mag[14:0], 1'b0};
            sin_sc  <= sin_sc + 4'd1;
          end
          if (!cos_norm) begin
            cos_mag <= {cos_mag[14:0], 1'b0};
            cos_sc  <= cos_sc + 4'd1;
          end
`ifndef Q2F_EARLY_DONE_EN
          cyc_cnt <= cyc_cnt + 4'd1;
`endif
        end
        PACK: begin
          sin_ieee754 <= pack(sin_sign, sin_mag, sin_sc);
          cos_ieee754 <= pack(cos_sign, cos_mag, cos_sc);
        end
        default: ;
      endcase
    end
  end

endmodule
